// File: rtl/shift_stage_skid.sv
// One handshaked stage of a pipelined logical-left barrel shifter, behind a 2-entry skid buffer.
// Optional transfer/stall counters are enabled by defining SHIFT_STAGE_CNT_EN.
module shift_stage_skid #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned AMT_W   = 5,
    parameter int unsigned SHIFT   = 2,
    parameter int unsigned SEL_BIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [AMT_W-1:0]  out_amt
`ifdef SHIFT_STAGE_CNT_EN
    ,
    output logic [15:0]       xfer_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic                w_in_xfer;
    logic                w_out_xfer;
    logic                w_load_m;
    logic                w_load_s;
    logic                w_m_from_s;
    logic [DATA_W-1:0]   w_shifted;
    logic [DATA_W-1:0]   r_m_data;
    logic [DATA_W-1:0]   r_s_data;
    logic [AMT_W-1:0]    r_m_amt;
    logic [AMT_W-1:0]    r_s_amt;

    // A shift distance >= DATA_W naturally yields zero.
    assign w_shifted  = in_amt[SEL_BIT] ? (in_data << SHIFT) : in_data;

    assign in_ready   = (r_state != StFull);
    assign out_valid  = (r_state != StEmpty);
    assign out_data   = r_m_data;
    assign out_amt    = r_m_amt;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_comb begin
        w_state_next = r_state;
        w_load_m     = 1'b0;
        w_load_s     = 1'b0;
        w_m_from_s   = 1'b0;
        unique case (r_state)
            StEmpty: begin
                if (w_in_xfer) begin
                    w_load_m     = 1'b1;
                    w_state_next = StOne;
                end
            end
            StOne: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_m = 1'b1;
                end else if (w_out_xfer) begin
                    w_state_next = StEmpty;
                end else if (w_in_xfer) begin
                    w_load_s     = 1'b1;
                    w_state_next = StFull;
                end
            end
            StFull: begin
                if (out_ready) begin
                    w_m_from_s   = 1'b1;
                    w_state_next = StOne;
                end
            end
            default: w_state_next = StEmpty;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_data <= '0;
            r_m_amt  <= '0;
            r_s_data <= '0;
            r_s_amt  <= '0;
        end else begin
            if (w_load_m) begin
                r_m_data <= w_shifted;
                r_m_amt  <= in_amt;
            end else if (w_m_from_s) begin
                r_m_data <= r_s_data;
                r_m_amt  <= r_s_amt;
            end
            if (w_load_s) begin
                r_s_data <= w_shifted;
                r_s_amt  <= in_amt;
            end
        end
    end

`ifdef SHIFT_STAGE_CNT_EN
    logic w_stall;
    assign w_stall = out_valid && !out_ready;

    // Transfer count wraps; stall count saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (w_out_xfer) begin
                xfer_cnt <= xfer_cnt + 16'd1;
            end
            if (w_stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_shift_stage_skid.sv
// Self-checking bench for shift_stage_skid: directed plan steps plus random traffic against a
// queue-based reference model.
module tb_shift_stage_skid;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_amt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_amt;
`ifdef SHIFT_STAGE_CNT_EN
    logic [15:0] xfer_cnt;
    logic [15:0] stall_cnt;
`endif

    shift_stage_skid #(
        .DATA_W  (32),
        .AMT_W   (5),
        .SHIFT   (2),
        .SEL_BIT (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_amt   (out_amt)
`ifdef SHIFT_STAGE_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  a;
    } word_t;

    word_t       q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] xfer_m;
    logic [15:0] stall_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference shift: multiply by 2**2 and keep the low 32 bits when amount bit 1 is set.
    function automatic word_t ref_word(input logic [31:0] d, input logic [4:0] a);
        longint unsigned p;
        word_t w;
        p   = a[1] ? (longint'(d) * 64'd4) : longint'(d);
        w.d = p[31:0];
        w.a = a;
        return w;
    endfunction

    task automatic check_model();
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        if (q.size() > 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_amt", {27'd0, out_amt}, {27'd0, q[0].a});
        end
`ifdef SHIFT_STAGE_CNT_EN
        chk("xfer_cnt", {16'd0, xfer_cnt}, {16'd0, xfer_m});
        chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, stall_m});
`endif
    endtask

    // Drive one cycle, advance the model at the edge, check 1 time unit later.
    task automatic cycle(input logic v, input logic [31:0] d, input logic [4:0] a,
                         input logic r);
        bit in_x;
        bit out_x;
        in_valid  = v;
        in_data   = d;
        in_amt    = a;
        out_ready = r;
        @(posedge clk);
        in_x  = v && (q.size() < 2);
        out_x = r && (q.size() > 0);
        if (q.size() > 0 && !r && stall_m != 16'hFFFF) stall_m = stall_m + 16'd1;
        if (out_x) begin
            void'(q.pop_front());
            xfer_m = xfer_m + 16'd1;
        end
        if (in_x) q.push_back(ref_word(d, a));
        #1;
        check_model();
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_amt", {27'd0, out_amt}, 32'd0);
        q.delete();
        xfer_m  = '0;
        stall_m = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        out_ready = 1'b0;
        xfer_m    = '0;
        stall_m   = '0;
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_data", out_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single word, selected.
        cycle(1'b1, 32'h8000_0001, 5'b00010, 1'b1);
        chk("single_data", out_data, 32'h0000_0004);
        chk("single_amt", {27'd0, out_amt}, 32'h2);
        cycle(1'b0, 32'h0, 5'b0, 1'b1);
        chk("single_one_cycle", {31'd0, out_valid}, 32'd0);

        // Unselected word passes through.
        cycle(1'b1, 32'hDEAD_BEEF, 5'b11101, 1'b1);
        chk("unsel_data", out_data, 32'hDEAD_BEEF);
        chk("unsel_amt", {27'd0, out_amt}, 32'h1D);
        cycle(1'b0, 32'h0, 5'b0, 1'b1);

        // Streaming 8 words.
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, i, 5'b00010, 1'b1);
            chk("stream_data", out_data, i * 4);
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
        end
        cycle(1'b0, 32'h0, 5'b0, 1'b1);

        // Backpressure: A, B, then C presented while full.
        cycle(1'b1, 32'h1, 5'b00010, 1'b0);
        cycle(1'b1, 32'h2, 5'b00010, 1'b0);
        chk("bp_hold_data", out_data, 32'h4);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        cycle(1'b1, 32'h5, 5'b00000, 1'b0);
        chk("bp_still_hold", out_data, 32'h4);
        cycle(1'b1, 32'h5, 5'b00000, 1'b1);
        chk("bp_second", out_data, 32'h8);
        cycle(1'b1, 32'h5, 5'b00000, 1'b1);
        chk("bp_third", out_data, 32'h5);
        cycle(1'b0, 32'h0, 5'b0, 1'b1);
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // Reset while full.
        cycle(1'b1, 32'hA, 5'b00010, 1'b0);
        cycle(1'b1, 32'hB, 5'b00010, 1'b0);
        async_reset();
        cycle(1'b1, 32'h3, 5'b00010, 1'b1);
        chk("post_rst_data", out_data, 32'hC);
        cycle(1'b0, 32'h0, 5'b0, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, 5'($urandom),
                  1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 5'b0, 1'b1);

`ifdef SHIFT_STAGE_CNT_EN
        async_reset();
        cycle(1'b1, 32'h1, 5'b00010, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 5'b0, 1'b0);
        cycle(1'b1, 32'h2, 5'b00010, 1'b1);
        cycle(1'b1, 32'h3, 5'b00010, 1'b1);
        cycle(1'b0, 32'h0, 5'b0, 1'b1);
        chk("cnt_xfer3", {16'd0, xfer_cnt}, 32'd3);
        chk("cnt_stall4", {16'd0, stall_cnt}, 32'd4);
        while (xfer_m != 16'hFFFF) cycle(1'b1, 32'h7, 5'b0, 1'b1);
        cycle(1'b0, 32'h0, 5'b0, 1'b1);
        chk("cnt_wrap", {16'd0, xfer_cnt}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
